// File: rtl/fetch_stage_core_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_stage_core_pkg;

   localparam int unsigned DEPTH  = 128;
   localparam int unsigned ADDR_W = 7;

   typedef logic [31:0] word_t;

   localparam word_t NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      PC_SEQ   = 2'd0,
      PC_HOLD  = 2'd1,
      PC_REDIR = 2'd2
   } pc_sel_e;

endpackage

// File: rtl/fetch_stage_core_if.sv
// Control, program-load and IF/ID signals between the pipeline and the fetch stage.
interface fetch_stage_core_if #(
   parameter int unsigned ADDR_W = fetch_stage_core_pkg::ADDR_W
);
   import fetch_stage_core_pkg::*;

   logic              ex_mem_pcsrc;
   word_t             ex_mem_npc;
   logic              stall;
   logic              flush;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   word_t             prog_data;
   word_t             pc_out;
   word_t             if_id_instr;
   word_t             if_id_npc;

   modport master (
      output ex_mem_pcsrc, ex_mem_npc, stall, flush, prog_we, prog_addr, prog_data,
      input  pc_out, if_id_instr, if_id_npc
   );

   modport slave (
      input  ex_mem_pcsrc, ex_mem_npc, stall, flush, prog_we, prog_addr, prog_data,
      output pc_out, if_id_instr, if_id_npc
   );

endinterface

// File: rtl/fetch_stage_core_imem.sv
// Word-addressed instruction memory: combinational read with range check, synchronous write.
module fetch_imem
   import fetch_stage_core_pkg::*;
#(
   parameter int unsigned DEPTH  = fetch_stage_core_pkg::DEPTH,
   parameter int unsigned ADDR_W = fetch_stage_core_pkg::ADDR_W,
   parameter word_t       NOP    = fetch_stage_core_pkg::NOP
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  word_t             i_wdata,
   input  word_t             i_raddr,
   output word_t             o_rdata
);

   word_t r_mem [DEPTH];
   logic  w_in_range;

   // Writes land at the edge, so a fetch captured at that same edge sees the old word.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign w_in_range = (i_raddr < 32'(DEPTH));
   assign o_rdata    = w_in_range ? r_mem[i_raddr[ADDR_W-1:0]] : NOP;

endmodule

// File: rtl/fetch_stage_core.sv
// MIPS IF stage: PC register, +1 word incrementer, instruction memory and IF/ID register.
module fetch_stage_core
   import fetch_stage_core_pkg::*;
#(
   parameter int unsigned DEPTH  = fetch_stage_core_pkg::DEPTH,
   parameter int unsigned ADDR_W = fetch_stage_core_pkg::ADDR_W,
   parameter word_t       NOP    = fetch_stage_core_pkg::NOP
) (
   input  logic                    clk,
   input  logic                    rst,
   fetch_stage_core_if.slave       bus
);

   word_t   r_pc;
   word_t   r_if_id_instr;
   word_t   r_if_id_npc;
   word_t   w_npc;
   word_t   w_instr;
   pc_sel_e w_pc_sel;

   fetch_imem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NOP    (NOP)
   ) u_imem (
      .i_clk   (clk),
      .i_we    (bus.prog_we),
      .i_waddr (bus.prog_addr),
      .i_wdata (bus.prog_data),
      .i_raddr (r_pc),
      .o_rdata (w_instr)
   );

   assign w_npc = r_pc + 32'd1;

   // Redirect outranks stall so a resolved branch is never lost behind a hazard.
   always_comb begin
      w_pc_sel = PC_SEQ;
      if (bus.ex_mem_pcsrc) begin
         w_pc_sel = PC_REDIR;
      end else if (bus.stall) begin
         w_pc_sel = PC_HOLD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= '0;
         r_if_id_instr <= NOP;
         r_if_id_npc   <= '0;
      end else begin
         case (w_pc_sel)
            PC_REDIR: r_pc <= bus.ex_mem_npc;
            PC_HOLD:  r_pc <= r_pc;
            default:  r_pc <= w_npc;
         endcase

         if (bus.flush) begin
            r_if_id_instr <= NOP;
            r_if_id_npc   <= '0;
         end else if (!bus.stall) begin
            r_if_id_instr <= w_instr;
            r_if_id_npc   <= w_npc;
         end
      end
   end

   assign bus.pc_out      = r_pc;
   assign bus.if_id_instr = r_if_id_instr;
   assign bus.if_id_npc   = r_if_id_npc;

endmodule

// File: tb/tb_fetch_stage_core.sv
// Directed bench for fetch_stage_core with hand-computed expected PC and IF/ID values.
module tb_fetch_stage_core;
   import fetch_stage_core_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned n_checks   = 0;
   int unsigned n_failures = 0;

   always #5 clk = ~clk;

   fetch_stage_core_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_stage_core #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NOP    (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_stage(input string tag, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] npc);
      check_eq({tag, ".pc"},    bus.pc_out,      pc);
      check_eq({tag, ".instr"}, bus.if_id_instr, instr);
      check_eq({tag, ".npc"},   bus.if_id_npc,   npc);
   endtask

   task automatic redirect(input logic [31:0] target);
      bus.ex_mem_pcsrc = 1'b1;
      bus.ex_mem_npc   = target;
      tick();
      bus.ex_mem_pcsrc = 1'b0;
      bus.ex_mem_npc   = '0;
   endtask

   task automatic load(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
      bus.prog_we   = 1'b1;
      bus.prog_addr = addr;
      bus.prog_data = data;
      tick();
      bus.prog_we   = 1'b0;
   endtask

   localparam logic [31:0] M0   = 32'h2008_0001;
   localparam logic [31:0] M1   = 32'h2009_0002;
   localparam logic [31:0] M2   = 32'h0109_5020;
   localparam logic [31:0] M3   = 32'hAC0A_0000;
   localparam logic [31:0] M4   = 32'h4444_4444;
   localparam logic [31:0] M5   = 32'h5555_5555;
   localparam logic [31:0] M127 = 32'h7F7F_7F7F;

   initial begin
      bus.ex_mem_pcsrc = 1'b0;
      bus.ex_mem_npc   = '0;
      bus.stall        = 1'b0;
      bus.flush        = 1'b0;
      bus.prog_we      = 1'b0;
      bus.prog_addr    = '0;
      bus.prog_data    = '0;

      // Program load happens while reset is held; memory is not touched by reset.
      load(7'd0, M0);
      load(7'd1, M1);
      load(7'd2, M2);
      load(7'd3, M3);
      load(7'd4, M4);
      load(7'd5, M5);
      load(7'd6, 32'h6666_6666);
      load(7'd127, M127);
      tick();
      check_stage("reset", 32'd0, NOP, 32'd0);

      rst = 1'b0;
      tick(); check_stage("run0", 32'd1, M0, 32'd1);
      tick(); check_stage("run1", 32'd2, M1, 32'd2);
      tick(); check_stage("run2", 32'd3, M2, 32'd3);
      tick(); check_stage("run3", 32'd4, M3, 32'd4);

      redirect(32'd2);
      check_stage("redir_to2", 32'd2, M4, 32'd5);
      redirect(32'd0);
      check_stage("redir_to0", 32'd0, M2, 32'd3);
      tick(); check_stage("after_redir", 32'd1, M0, 32'd1);

      bus.stall = 1'b1;
      tick(); check_stage("stall1", 32'd1, M0, 32'd1);
      tick(); check_stage("stall2", 32'd1, M0, 32'd1);
      bus.stall = 1'b0;
      bus.flush = 1'b1;
      tick(); check_stage("flush", 32'd2, NOP, 32'd0);
      bus.flush = 1'b0;
      tick(); check_stage("post_flush", 32'd3, M2, 32'd3);

      bus.stall = 1'b1;
      redirect(32'd5);
      check_stage("stall_redir", 32'd5, M2, 32'd3);
      bus.stall = 1'b0;
      tick(); check_stage("fetch5", 32'd6, M5, 32'd6);

      bus.stall = 1'b1;
      bus.flush = 1'b1;
      tick(); check_stage("stall_flush", 32'd6, NOP, 32'd0);
      bus.stall = 1'b0;
      bus.flush = 1'b0;

      redirect(32'd127);
      check_eq("redir127.pc", bus.pc_out, 32'd127);
      tick(); check_stage("fetch127", 32'd128, M127, 32'd128);
      tick(); check_stage("fetch128", 32'd129, NOP, 32'd129);

      redirect(32'hFFFF_FFFF);
      check_eq("redir_max.pc", bus.pc_out, 32'hFFFF_FFFF);
      tick(); check_stage("wrap", 32'd0, NOP, 32'd0);

      redirect(32'd3);
      check_eq("redir3.pc", bus.pc_out, 32'd3);
      bus.prog_we   = 1'b1;
      bus.prog_addr = 7'd3;
      bus.prog_data = 32'hDEAD_BEEF;
      tick(); check_stage("rdw_old", 32'd4, M3, 32'd4);
      bus.prog_we = 1'b0;
      redirect(32'd3);
      tick(); check_stage("rdw_new", 32'd4, 32'hDEAD_BEEF, 32'd4);

      rst       = 1'b1;
      bus.stall = 1'b1;
      bus.flush = 1'b0;
      redirect(32'd9);
      check_stage("midrst", 32'd0, NOP, 32'd0);
      rst       = 1'b0;
      bus.stall = 1'b0;
      tick(); check_stage("post_rst0", 32'd1, M0, 32'd1);
      tick(); check_stage("post_rst1", 32'd2, M1, 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
